// File: rtl/ei_mult_arbiter.sv
// ei_mult_arbiter: round-robin front end for one shared pipelined multiplier.
// It grants one requester per cycle and issues that requester's operands to
// the multiplier. A requester tag travels alongside each operation, so every
// product is returned to the requester that issued it, in issue order.
module ei_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int MUL_LAT = 2,   // must be >= 1
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,        // asynchronous, active-low
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [IW-1:0]        rsp_id,
  output logic [2*DW-1:0]      rsp_data,
  output logic                 mul_en,
  output logic [DW-1:0]        mul_a,
  output logic [DW-1:0]        mul_b,
  input  logic [2*DW-1:0]      mul_c,
  output logic                 busy
);

  logic [IW-1:0]  ptr;
  logic           grant_found;
  logic [IW-1:0]  grant_idx;

  // Tag pipeline: stage j holds the op issued j edges ago. The last stage
  // lines up with the cycle in which that op's product sits on mul_c.
  logic [MUL_LAT:0] tag_valid;
  logic [IW-1:0]    tag_id [MUL_LAT+1];

  // Round-robin search starting at ptr and wrapping; no grant while in reset.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx[IW-1:0];
      end
    end
    if (!rst) begin
      grant_found = 1'b0;
    end
  end

  assign req_ready = grant_found ? (NREQ'(1) << grant_idx) : '0;

  // The pointer moves just past the granted requester; it holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (grant_found) begin
      ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Issue stage: latch the granted operands and hold them when idle. The enable
  // stays high while any op still needs the multiplier pipeline to advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a  <= '0;
      mul_b  <= '0;
      mul_en <= 1'b0;
    end else begin
      if (grant_found) begin
        mul_a <= req_a[grant_idx*DW +: DW];
        mul_b <= req_b[grant_idx*DW +: DW];
      end
      mul_en <= grant_found | (|tag_valid[MUL_LAT-1:0]);
    end
  end

  // Stage 0 of the tag pipeline: a valid tag on a transfer, a bubble otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid[0] <= 1'b0;
      tag_id[0]    <= '0;
    end else begin
      tag_valid[0] <= grant_found;
      tag_id[0]    <= grant_idx;
    end
  end

  generate
    for (genvar gi = 1; gi <= MUL_LAT; gi++) begin : g_tag
      // Shift the tag one stage further each cycle. A reset drops every op in flight.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tag_valid[gi] <= 1'b0;
          tag_id[gi]    <= '0;
        end else begin
          tag_valid[gi] <= tag_valid[gi-1];
          tag_id[gi]    <= tag_id[gi-1];
        end
      end
    end
  endgenerate

  // Capture the product for the tag in the last stage. A bubble only clears
  // the strobe, so the data and id outputs keep their last values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (tag_valid[MUL_LAT]) begin
      rsp_valid <= NREQ'(1) << tag_id[MUL_LAT];
      rsp_id    <= tag_id[MUL_LAT];
      rsp_data  <= mul_c;
    end else begin
      rsp_valid <= '0;
    end
  end

  // Every op still waiting for its capture edge holds a valid tag.
  assign busy = |tag_valid;

endmodule

// File: tb/tb_ei_mult_arbiter.sv
// Bench for ei_mult_arbiter: a behavioural multiplier, a round-robin grant
// model and a scoreboard queue of expected responses, plus a decoupled monitor.
module tb_ei_mult_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 8;
  localparam int MUL_LAT = 2;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*DW-1:0] req_a = '0, req_b = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [2*DW-1:0]   rsp_data;
  logic              mul_en;
  logic [DW-1:0]     mul_a, mul_b;
  logic [2*DW-1:0]   mul_c;
  logic              busy;

  ei_mult_arbiter #(.NREQ(NREQ), .DW(DW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_c(mul_c), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: MUL_LAT register stages that advance only when enabled.
  logic [2*DW-1:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    if (mul_en) begin
      mpipe[0] <= {{DW{1'b0}}, mul_a} * {{DW{1'b0}}, mul_b};
      for (int j = 1; j < MUL_LAT; j++) mpipe[j] <= mpipe[j-1];
    end
  end
  assign mul_c = mpipe[MUL_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              id;
    logic [2*DW-1:0] prod;
    int              due;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;
  int model_ptr = 0;
  bit run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of requests, check the grant against the model and queue the response.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] a,
                      input logic [NREQ*DW-1:0] b);
    int g;
    int idx;
    logic [NREQ-1:0] exp_ready;
    logic [2*DW-1:0] pa;
    logic [2*DW-1:0] pb;
    @(negedge clk);
    req_valid = v;
    req_a = a;
    req_b = b;
    #1;
    g = -1;
    for (int off = 0; off < NREQ; off++) begin
      idx = (model_ptr + off) % NREQ;
      if (g < 0 && v[idx]) g = idx;
    end
    exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("grant", 32'(req_ready), 32'(exp_ready));
    if (g >= 0) begin
      pa = {{DW{1'b0}}, a[g*DW +: DW]};
      pb = {{DW{1'b0}}, b[g*DW +: DW]};
      q.push_back('{id: g, prod: pa * pb, due: cyc + MUL_LAT + 2});
      $display("issue  id=%0d a=%0d b=%0d cyc=%0d", g, a[g*DW +: DW], b[g*DW +: DW], cyc);
      model_ptr = (g + 1) % NREQ;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    q.delete();
    model_ptr = 0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mul_en", 32'(mul_en), 32'd0);
    chk("rst_mul_ab", {16'd0, mul_a, mul_b}, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: sample after each rising edge and compare against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (run) begin
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << e.id));
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_data", 32'(rsp_data), 32'(e.prod));
          $display("rsp    id=%0d data=%0h exp_id=%0d exp_data=%0h cyc=%0d",
                   rsp_id, rsp_data, e.id, e.prod, cyc);
        end else begin
          chk("rsp_quiet", 32'(rsp_valid), 32'd0);
        end
        chk("busy", 32'(busy), 32'(q.size() > 0));
        chk("mul_en", 32'(mul_en), 32'(q.size() > 0));
      end
    end
  end

  // Stimulus
  initial begin
    logic [NREQ*DW-1:0] a, b;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run = 1;

    // Single op from requester 0, then idle long enough to drain.
    step(4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd4});
    repeat (6) step('0, '0, '0);

    // Full load: a = i+1 and b = 10 for every requester.
    for (int i = 0; i < NREQ; i++) begin
      a[i*DW +: DW] = DW'(i + 1);
      b[i*DW +: DW] = 8'd10;
    end
    repeat (8) step('1, a, b);
    repeat (5) step('0, '0, '0);

    // Wrap case: grant requester 2, then requesters 3 and 0 compete, then check the pointer is at 1.
    step(4'b0100, a, b);
    step(4'b1001, a, b);
    step(4'b0001, a, b);
    step(4'b0011, a, b);
    repeat (5) step('0, '0, '0);

    // Corner operands.
    step(4'b0001, {8'd0, 8'd0, 8'd0, 8'd255}, {8'd0, 8'd0, 8'd0, 8'd255});
    step(4'b0010, {8'd0, 8'd0, 8'd0, 8'd0},   {8'd0, 8'd0, 8'd200, 8'd0});
    step(4'b0100, {8'd0, 8'd1, 8'd0, 8'd0},   {8'd0, 8'd255, 8'd0, 8'd0});
    repeat (5) step('0, '0, '0);

    // Reset with two ops in flight; the next grant must go to requester 0.
    step(4'b0010, a, b);
    step(4'b0100, a, b);
    do_reset();
    repeat (3) step('0, '0, '0);
    step('1, a, b);
    repeat (5) step('0, '0, '0);

    // Random traffic with occasional corner operands.
    for (int n = 0; n < 400; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) a = '1;
      if ($urandom_range(0, 7) == 0) b = '1;
      step(NREQ'($urandom_range(0, (1 << NREQ) - 1)), a, b);
    end
    repeat (8) step('0, '0, '0);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
